l2_sample_driver: RTL and testbench

L2_SAMPLE_DRIVER -- requirements
Module: l2_sample_driver

---
 rtl/l2_sample_driver.sv | 168 ++++++++++++++++
 tb/tb_l2_sample_driver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_sample_driver.sv
// Sample FIFO plus a send/collect FSM feeding an L2 accumulator.
// Samples are queued in IDLE, streamed out on start, and the accumulator's last f is kept as the result.
module l2_sample_driver #(
    parameter int DEPTH = 8,
    parameter int TMO   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             load_data,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   start,
    input  logic [$clog2(DEPTH):0] len,
    input  logic                   hold,
    output logic [7:0]             a,
    output logic                   valid_in,
    input  logic [19:0]            f,
    input  logic                   valid_out,
    output logic [19:0]            result,
    output logic [19:0]            result_prev,
    output logic                   done,
    output logic [1:0]             err,
    output logic [1:0]             state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   sent;
    logic [LW-1:0]   returned;
    logic [LW-1:0]   ret_next;
    logic [TW-1:0]   tmo_cnt;
    logic [19:0]     last_f;
    logic [19:0]     f_next;
    logic            rdy_en;
    logic            push;
    logic            pop;
    logic            collecting;

    // load: a sample transfers on any rising edge where load_valid && load_ready;
    // load_valid while load_ready is low is simply discarded, nothing is held over.
    assign load_ready = rdy_en && (state == IDLE) && (count != LW'(DEPTH));
    assign push       = load_valid && load_ready;
    assign pop        = (state == SEND) && !hold;
    assign collecting = (state == SEND) || (state == WAIT);
    assign ret_next   = returned + LW'(valid_out);
    assign f_next     = valid_out ? f : last_f;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rdy_en      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            len_q       <= '0;
            sent        <= '0;
            returned    <= '0;
            tmo_cnt     <= '0;
            last_f      <= '0;
            a           <= '0;
            valid_in    <= 1'b0;
            result      <= '0;
            result_prev <= '0;
            done        <= 1'b0;
            err         <= 2'd0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + LW'(push) - LW'(pop);

            if (collecting && valid_out) begin
                returned <= ret_next;
                last_f   <= f;
            end

            case (state)
                IDLE: begin
                    valid_in <= 1'b0;
                    done     <= 1'b0;
                    if (start && (len != '0)) begin
                        if (len <= count) begin
                            err      <= 2'd0;
                            sent     <= '0;
                            returned <= '0;
                            tmo_cnt  <= '0;
                            len_q    <= len;
                            state    <= SEND;
                        end else begin
                            err   <= 2'd1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SEND: begin
                    done <= 1'b0;
                    if (valid_out) begin
                        tmo_cnt <= '0;
                    end
                    if (!hold) begin
                        a        <= mem[rd_ptr];
                        valid_in <= 1'b1;
                        sent     <= sent + LW'(1);
                        if ((sent + LW'(1)) == len_q) begin
                            state <= WAIT;
                        end
                    end else begin
                        valid_in <= 1'b0;
                    end
                end
                WAIT: begin
                    valid_in <= 1'b0;
                    // a valid_out landing on the final count is folded in through f_next
                    if (ret_next == len_q) begin
                        result_prev <= result;
                        result      <= f_next;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (valid_out) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        err   <= 2'd2;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                DONE: begin
                    valid_in <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_sample_driver.sv
// Directed bench for l2_sample_driver with a sum-of-squares accumulator model at latency 1.
// Expected samples go through a queue; result/err values are hand-computed.
module tb_l2_sample_driver;

    localparam int DEPTH = 8;
    localparam int TMO   = 15;
    localparam int LW    = 4;

    logic          clk;
    logic          reset;
    logic [7:0]    load_data;
    logic          load_valid;
    logic          load_ready;
    logic          start;
    logic [LW-1:0] len;
    logic          hold;
    logic [7:0]    a;
    logic          valid_in;
    logic [19:0]   f;
    logic          valid_out;
    logic [19:0]   result;
    logic [19:0]   result_prev;
    logic          done;
    logic [1:0]    err;
    logic [1:0]    state_dbg;

    l2_sample_driver #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .start       (start),
        .len         (len),
        .hold        (hold),
        .a           (a),
        .valid_in    (valid_in),
        .f           (f),
        .valid_out   (valid_out),
        .result      (result),
        .result_prev (result_prev),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // accumulator model: running sum of squares, f/valid_out one cycle after valid_in
    logic [19:0] m_sum  = '0;
    logic [19:0] pend_f = '0;
    logic        pend   = 1'b0;
    int          m_iss  = 0;
    int          ret_limit = 99;
    int          vo_cyc = 0;

    always @(posedge clk) begin
        #1;
        valid_out = pend;
        f         = pend_f;
        if (pend) vo_cyc = cyc;
        pend = 1'b0;
        if (!reset && valid_in) begin
            m_sum  = m_sum + 20'(a) * 20'(a);
            pend_f = m_sum;
            if (m_iss < ret_limit) begin
                pend = 1'b1;
                m_iss++;
            end
        end
    end

    // scoreboard on the sample stream
    logic [7:0] exp_q[$];
    int vi_n    = 0;
    int vi_last = 0;
    int vi_gap  = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (valid_in) begin
            vi_n++;
            if (vi_n > 1 && (cyc - vi_last) > vi_gap) vi_gap = cyc - vi_last;
            vi_last = cyc;
            if (exp_q.size() == 0) check("extra_valid_in", 32'd1, 32'd0);
            else check("sample_a", 32'(a), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic clear_mon();
        vi_n   = 0;
        vi_gap = 0;
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        load_data  = v;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic start_vec(input int n);
        @(negedge clk);
        m_sum = '0;
        m_iss = 0;
        clear_mon();
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = '0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        else done_cyc = cyc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid_in"}, 32'(valid_in), 32'd0);
        check({tag, "_a"}, 32'(a), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_result_prev"}, 32'(result_prev), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b1; load_data = '0; load_valid = 1'b0;
        start = 1'b0; len = '0; hold = 1'b0;
        valid_out = 1'b0; f = '0;

        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        #1 check("rdy_before_edge", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1 check("rdy_after_edge", 32'(load_ready), 32'd1);

        // 3,4 -> 9+16
        load(8'd3); load(8'd4);
        exp_q.push_back(8'd3); exp_q.push_back(8'd4);
        start_vec(2);
        wait_done(100);
        check("v1_result", 32'(result), 32'd25);
        check("v1_err", 32'(err), 32'd0);
        check("v1_pulses", 32'(vi_n), 32'd2);
        check("v1_consecutive", 32'(vi_gap), 32'd1);
        @(negedge clk);
        check("v1_done_one_cycle", 32'(done), 32'd0);

        // 1,2 -> 1+4, previous kept
        load(8'd1); load(8'd2);
        exp_q.push_back(8'd1); exp_q.push_back(8'd2);
        start_vec(2);
        wait_done(100);
        check("v2_result", 32'(result), 32'd5);
        check("v2_result_prev", 32'(result_prev), 32'd25);

        // fill FIFO, extra load dropped, 2-cycle hold gap
        for (int i = 0; i < DEPTH; i++) load(8'(10 + i));
        @(negedge clk);
        check("full_load_ready", 32'(load_ready), 32'd0);
        load(8'd99);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(10 + i));
        start_vec(DEPTH);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        hold = 1'b0;
        wait_done(100);
        check("full_pulses", 32'(vi_n), DEPTH);
        check("full_hold_gap", 32'(vi_gap), 32'd3);
        check("full_result", 32'(result), 32'd1500);
        check("full_err", 32'(err), 32'd0);

        // underrun leaves the FIFO alone
        load(8'd7);
        start_vec(2);
        wait_done(20);
        check("under_err", 32'(err), 32'd1);
        check("under_pulses", 32'(vi_n), 32'd0);
        check("under_result", 32'(result), 32'd1500);
        exp_q.push_back(8'd7);
        start_vec(1);
        wait_done(100);
        check("after_under_result", 32'(result), 32'd49);
        check("after_under_prev", 32'(result_prev), 32'd1500);
        check("after_under_err", 32'(err), 32'd0);

        // only one of two results returns -> timeout
        load(8'd5); load(8'd6);
        exp_q.push_back(8'd5); exp_q.push_back(8'd6);
        ret_limit = 1;
        start_vec(2);
        wait_done(100);
        ret_limit = 99;
        check("tmo_err", 32'(err), 32'd2);
        check("tmo_result", 32'(result), 32'd49);
        check("tmo_result_prev", 32'(result_prev), 32'd1500);
        // valid_out captured at the edge after its window; done TMO edges after that
        check("tmo_latency", 32'(done_cyc - vo_cyc), 32'(TMO + 1));

        // reset mid-SEND
        load(8'd1); load(8'd2); load(8'd3); load(8'd4);
        exp_q.push_back(8'd1);
        start_vec(4);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("midrst");
        check("midrst_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("midrst_rdy", 32'(load_ready), 32'd1);
        start_vec(1);
        wait_done(20);
        check("midrst_empty_err", 32'(err), 32'd1);
        load(8'd9);
        exp_q.push_back(8'd9);
        start_vec(1);
        wait_done(100);
        check("post_rst_result", 32'(result), 32'd81);
        check("post_rst_prev", 32'(result_prev), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_pulses", 32'(vi_n), 32'd1);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
